// File: rtl/uart_line_rx.sv
// rtl/uart_line_rx.sv - 8N1 UART receiver with CR LF line assembler (optional backspace editing via UART_LINE_BS_EN)
module uart_line_rx #(
    parameter int CLK_DIV    = 434,
    parameter int LINE_BYTES = 15
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RXD,
    output logic [8*LINE_BYTES-1:0] LINE_DATA,
    output logic                    LINE_VALID,
    input  logic                    LINE_READY,
    output logic                    FRAME_ERR,
    output logic                    OVERFLOW,
    output logic                    OVERRUN
);

    localparam int              W        = 8 * LINE_BYTES;
    localparam int              CW       = $clog2(LINE_BYTES + 1);
    localparam logic [CW-1:0]   LB       = CW'(LINE_BYTES);
    localparam logic [15:0]     CNT_FULL = 16'(CLK_DIV - 1);
    localparam logic [15:0]     CNT_HALF = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // synchroniser
    logic           r_rxd_meta;
    logic           r_rxd_sync;

    // bit engine
    state_t         r_state;
    logic [15:0]    r_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_frame_err;

    // line assembly
    logic [W-1:0]   r_buf;
    logic [CW-1:0]  r_count;
    logic [7:0]     r_prev;
    logic           r_discard;
    logic           r_overflow;

    // output stage
    logic [W-1:0]   r_line_data;
    logic           r_line_valid;
    logic           r_overrun;

    logic           w_byte_ok;
    logic [7:0]     w_rx_byte;
    logic           w_crlf;
    logic           w_complete;
    logic [W-1:0]   w_line;

    // Stop bit sampled high in this cycle: r_shift holds a complete good byte.
    assign w_byte_ok  = (r_state == ST_STOP) && (r_cnt == 16'd0) && r_rxd_sync;
    assign w_rx_byte  = r_shift;
    assign w_crlf     = (w_rx_byte == 8'h0A) && (r_prev == 8'h0D);
    // Room for the LF is required; a CR in the last slot means the line is too long.
    assign w_complete = w_byte_ok && !r_discard && w_crlf && (r_count < LB);
    assign w_line     = (r_buf << 8) | {{(W-8){1'b0}}, 8'h0A};

    assign LINE_DATA  = r_line_data;
    assign LINE_VALID = r_line_valid;
    assign FRAME_ERR  = r_frame_err;
    assign OVERFLOW   = r_overflow;
    assign OVERRUN    = r_overrun;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= RXD;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // Bit FSM: mid-bit sampling of start, eight data bits LSB first, and stop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_rxd_sync) begin
                        r_state <= ST_START;
                        r_cnt   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (!r_rxd_sync) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= 3'd0;
                        r_cnt     <= CNT_FULL;
                    end else begin
                        // Low pulse shorter than half a bit: treat as noise.
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_shift <= {r_rxd_sync, r_shift[7:1]};
                        r_cnt   <= CNT_FULL;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (r_rxd_sync) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    // Hold here until the line returns high so a break reports once.
                    if (r_rxd_sync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line assembler: pack accepted bytes right-aligned, detect CR LF and overflow.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_buf      <= '0;
            r_count    <= '0;
            r_prev     <= 8'd0;
            r_discard  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (w_byte_ok) begin
                r_prev <= w_rx_byte;
                if (r_discard) begin
                    // Drop the rest of an overlong line; resynchronise on its CR LF.
                    if (w_crlf) begin
                        r_buf     <= '0;
                        r_count   <= '0;
                        r_discard <= 1'b0;
                    end
                end else if (w_complete) begin
                    r_buf   <= '0;
                    r_count <= '0;
`ifdef UART_LINE_BS_EN
                end else if (w_rx_byte == 8'h08) begin
                    if (r_count != '0) begin
                        r_buf   <= r_buf >> 8;
                        r_count <= r_count - 1'b1;
                    end
`endif
                end else if (r_count < LB) begin
                    r_buf   <= (r_buf << 8) | {{(W-8){1'b0}}, w_rx_byte};
                    r_count <= r_count + 1'b1;
                end else begin
                    r_discard  <= 1'b1;
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Output holding register with valid/ready; a line finishing while one is held is dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_line_data  <= '0;
            r_line_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_line_valid || LINE_READY) begin
                    r_line_data  <= w_line;
                    r_line_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_line_valid && LINE_READY) begin
                r_line_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_line_rx.sv
// tb/tb_uart_line_rx.sv - directed table-driven bench for uart_line_rx
module tb_uart_line_rx;

    localparam int CLK_DIV    = 16;
    localparam int LINE_BYTES = 15;
    localparam int W          = 8 * LINE_BYTES;

    logic           CLK;
    logic           RST;
    logic           RXD;
    logic [W-1:0]   LINE_DATA;
    logic           LINE_VALID;
    logic           LINE_READY;
    logic           FRAME_ERR;
    logic           OVERFLOW;
    logic           OVERRUN;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int ovf_cnt = 0;
    int orun_cnt = 0;

    uart_line_rx #(
        .CLK_DIV    (CLK_DIV),
        .LINE_BYTES (LINE_BYTES)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RXD        (RXD),
        .LINE_DATA  (LINE_DATA),
        .LINE_VALID (LINE_VALID),
        .LINE_READY (LINE_READY),
        .FRAME_ERR  (FRAME_ERR),
        .OVERFLOW   (OVERFLOW),
        .OVERRUN    (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FRAME_ERR) fe_cnt++;
        if (OVERFLOW)  ovf_cnt++;
        if (OVERRUN)   orun_cnt++;
    end

    typedef struct {
        string          s;
        logic           v;
        logic [W-1:0]   d;
        int             ovf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        repeat (CLK_DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CLK_DIV) @(negedge CLK);
        end
        RXD = stop;
        repeat (CLK_DIV) @(negedge CLK);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
            repeat (2) @(negedge CLK);
        end
    endtask

    task automatic xfer();
        LINE_READY = 1'b1;
        @(negedge CLK);
        LINE_READY = 1'b0;
        chk("xfer_valid_low", W'(LINE_VALID), W'(0));
    endtask

    int fe0, ovf0, or0;

    initial begin
        tbl[0] = '{s: "R_30\r\n",             v: 1'b1, d: 120'h525F33300D0A,                   ovf: 0};
        tbl[1] = '{s: "\r\n",                 v: 1'b1, d: 120'h0D0A,                           ovf: 0};
        tbl[2] = '{s: "\r\r\n",               v: 1'b1, d: 120'h0D0D0A,                         ovf: 0};
        tbl[3] = '{s: "A\nB\r\n",             v: 1'b1, d: 120'h410A420D0A,                     ovf: 0};
        tbl[4] = '{s: "ABCDEFGHIJKLM\r\n",    v: 1'b1, d: 120'h4142434445464748494A4B4C4D0D0A, ovf: 0};
        tbl[5] = '{s: "AAAAAAAAAAAAAAAA\r\n", v: 1'b0, d: 120'h0,                              ovf: 1};
        tbl[6] = '{s: "W_31\r\n",             v: 1'b1, d: 120'h575F33310D0A,                   ovf: 0};

        RST = 1'b0;
        RXD = 1'b1;
        LINE_READY = 1'b0;
        repeat (5) @(negedge CLK);
        chk("rst_data",  LINE_DATA, W'(0));
        chk("rst_valid", W'(LINE_VALID), W'(0));
        chk("rst_pulses", W'({FRAME_ERR, OVERFLOW, OVERRUN}), W'(0));
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // table of complete lines, including overflow and maximum-length cases
        foreach (tbl[k]) begin
            fe0 = fe_cnt; ovf0 = ovf_cnt; or0 = orun_cnt;
            send_str(tbl[k].s);
            chk($sformatf("tbl%0d_valid", k), W'(LINE_VALID), W'(tbl[k].v));
            if (tbl[k].v) chk($sformatf("tbl%0d_data", k), LINE_DATA, tbl[k].d);
            chk($sformatf("tbl%0d_ovf", k), W'(ovf_cnt - ovf0), W'(tbl[k].ovf));
            chk($sformatf("tbl%0d_fe", k), W'(fe_cnt - fe0), W'(0));
            chk($sformatf("tbl%0d_orun", k), W'(orun_cnt - or0), W'(0));
            if (tbl[k].v) xfer();
        end

        // overrun: second line dropped while first is held
        or0 = orun_cnt;
        send_str("R_30\r\n");
        send_str("R_31\r\n");
        chk("orun_valid", W'(LINE_VALID), W'(1));
        chk("orun_held", LINE_DATA, 120'h525F33300D0A);
        chk("orun_pulse", W'(orun_cnt - or0), W'(1));
        xfer();
        repeat (50) @(negedge CLK);
        chk("orun_no_second", W'(LINE_VALID), W'(0));

        // framing error followed by a long break
        fe0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        repeat (40 * CLK_DIV) @(negedge CLK);
        RXD = 1'b1;
        repeat (20) @(negedge CLK);
        chk("fe_once", W'(fe_cnt - fe0), W'(1));
        chk("fe_no_line", W'(LINE_VALID), W'(0));
        send_str("R_30\r\n");
        chk("fe_after_valid", W'(LINE_VALID), W'(1));
        chk("fe_after_data", LINE_DATA, 120'h525F33300D0A);
        xfer();

        // short glitch on idle line
        fe0 = fe_cnt; ovf0 = ovf_cnt;
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        RXD = 1'b1;
        repeat (100) @(negedge CLK);
        chk("glitch_valid", W'(LINE_VALID), W'(0));
        chk("glitch_err", W'((fe_cnt - fe0) + (ovf_cnt - ovf0)), W'(0));
        send_str("R_30\r\n");
        chk("glitch_after", LINE_DATA, 120'h525F33300D0A);

        // reset mid-frame with a line still pending
        RXD = 1'b0;
        repeat (4 * CLK_DIV) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("mid_rst_valid", W'(LINE_VALID), W'(0));
        chk("mid_rst_data", LINE_DATA, W'(0));
        repeat (3) @(negedge CLK);
        RXD = 1'b1;
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        send_str("R_31\r\n");
        chk("post_rst_valid", W'(LINE_VALID), W'(1));
        chk("post_rst_data", LINE_DATA, 120'h525F33310D0A);
        xfer();

        // backspace handling
        send_str("R_3X");
        send_byte(8'h08, 1'b1);
        repeat (2) @(negedge CLK);
        send_str("0\r\n");
        chk("bs_valid", W'(LINE_VALID), W'(1));
`ifdef UART_LINE_BS_EN
        chk("bs_data", LINE_DATA, 120'h525F33300D0A);
`else
        chk("bs_data", LINE_DATA, 120'h525F335808300D0A);
`endif
        xfer();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
